// File: rtl/spi_slave_if.sv
// SPI pins plus the byte-level TX/RX handshake of the SPI responder.
// The slave modport is the responder's view; master is the initiator/host view.
interface spi_slave_if;
    logic       spi_cs_n;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_miso;
    logic       miso_oe;
    logic [7:0] tx_data;
    logic       tx_write;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;

    modport slave (
        input  spi_cs_n, spi_sclk, spi_mosi, tx_data, tx_write,
        output spi_miso, miso_oe, tx_ready, rx_data, rx_valid, busy
    );

    modport master (
        output spi_cs_n, spi_sclk, spi_mosi, tx_data, tx_write,
        input  spi_miso, miso_oe, tx_ready, rx_data, rx_valid, busy
    );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 responder, MSB first, 8-bit frames, oversampled in the clk domain.
// One-byte TX holding register feeds the TX shifter; received bytes are strobed out.
module spi_slave #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
    input  logic        clk,
    input  logic        rst_n,
    spi_slave_if.slave  bus
);

    typedef enum logic {IDLE, SELECTED} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
    logic                   sclk_prev, cs_prev;
    logic                   sclk_s, mosi_s, cs_s;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [7:0]             tx_shift, rx_shift, hold_data, rx_data_r;
    logic [2:0]             bit_cnt;
    logic                   seen_rise;
    logic                   tx_ready_r, miso_oe_r, rx_valid_r;
    logic                   bypass, do_load;
    logic [7:0]             load_byte;

    // Inputs come straight from pads; reset values are the inactive bus levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            mosi_sync <= '1;
            cs_sync   <= '1;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.spi_sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.spi_cs_n};
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign cs_rise   = cs_s & ~cs_prev;
    assign cs_fall   = ~cs_s & cs_prev;

    // A load happens at CS assertion and at each byte boundary once the first rise was seen.
    assign bypass    = bus.tx_write & tx_ready_r;
    assign load_byte = !tx_ready_r ? hold_data : (bypass ? bus.tx_data : IDLE_BYTE);
    assign do_load   = ((state == IDLE) && cs_fall) ||
                       ((state == SELECTED) && !cs_rise && sclk_fall &&
                        (bit_cnt == 3'd0) && seen_rise);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tx_shift   <= IDLE_BYTE;
            rx_shift   <= 8'h00;
            hold_data  <= 8'h00;
            rx_data_r  <= 8'h00;
            bit_cnt    <= 3'd0;
            seen_rise  <= 1'b0;
            tx_ready_r <= 1'b1;
            miso_oe_r  <= 1'b0;
            rx_valid_r <= 1'b0;
        end else begin
            rx_valid_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state     <= SELECTED;
                        miso_oe_r <= 1'b1;
                        bit_cnt   <= 3'd0;
                        seen_rise <= 1'b0;
                        rx_shift  <= 8'h00;
                    end
                end
                SELECTED: begin
                    if (cs_rise) begin
                        state     <= IDLE;
                        miso_oe_r <= 1'b0;
                        bit_cnt   <= 3'd0;
                        seen_rise <= 1'b0;
                        rx_shift  <= 8'h00;
                        tx_shift  <= IDLE_BYTE;
                    end else if (sclk_rise) begin
                        rx_shift  <= {rx_shift[6:0], mosi_s};
                        bit_cnt   <= bit_cnt + 3'd1;
                        seen_rise <= 1'b1;
                        if (bit_cnt == 3'd7) begin
                            rx_data_r  <= {rx_shift[6:0], mosi_s};
                            rx_valid_r <= 1'b1;
                        end
                    end else if (sclk_fall && (bit_cnt != 3'd0)) begin
                        tx_shift <= {tx_shift[6:0], 1'b1};
                    end
                end
                default: state <= IDLE;
            endcase

            // Writes that coincide with a load while empty bypass into the shifter instead.
            if (do_load) begin
                tx_shift <= load_byte;
                if (!tx_ready_r) tx_ready_r <= 1'b1;
            end else if (bypass) begin
                hold_data  <= bus.tx_data;
                tx_ready_r <= 1'b0;
            end
        end
    end

    assign bus.spi_miso = tx_shift[7];
    assign bus.miso_oe  = miso_oe_r;
    assign bus.tx_ready = tx_ready_r;
    assign bus.rx_data  = rx_data_r;
    assign bus.rx_valid = rx_valid_r;
    assign bus.busy     = (state == SELECTED) && (bit_cnt != 3'd0);

endmodule
